trig_arbiter: RTL and testbench

TRIG_ARBITER -- requirements
Module: trig_arbiter

---
 rtl/trig_arbiter_if.sv | 32 +++
 rtl/trig_arbiter.sv | 160 ++++++++++++++++
 tb/tb_trig_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_arbiter_if.sv
// trig_arbiter_if: request/control inputs and fire/status outputs of trig_arbiter.
interface trig_arbiter_if #(
    parameter int NCH = 16
);
    // There is no valid/ready handshake on this bus. req is a level that is
    // sampled on every clk_adc edge. All outputs are registered status that
    // changes on that same edge. The master drives the controls and the slave
    // (the arbiter) drives the status.
    logic [NCH-1:0] req;
    logic [NCH-1:0] chan_mask;
    logic           enable;
    logic [31:0]    randnum;
    logic [31:0]    prescale;
    logic           clear_counts;
    logic [NCH-1:0] fire_out;
    logic           busy;
    logic [3:0]     grant_id;
    logic [31:0]    accepted_cnt;
    logic [31:0]    vetoed_cnt;
    logic [31:0]    lost_cnt;
    logic [1:0]     fsm_state;

    modport master (
        output req, chan_mask, enable, randnum, prescale, clear_counts,
        input  fire_out, busy, grant_id, accepted_cnt, vetoed_cnt, lost_cnt, fsm_state
    );

    modport slave (
        input  req, chan_mask, enable, randnum, prescale, clear_counts,
        output fire_out, busy, grant_id, accepted_cnt, vetoed_cnt, lost_cnt, fsm_state
    );
endinterface

// File: rtl/trig_arbiter.sv
// trig_arbiter: round-robin trigger arbiter with prescale veto, a fixed-length
// fire pulse, a deadtime, and saturating event counters. NCH must be 2..16.
module trig_arbiter #(
    parameter int NCH      = 16,
    parameter int FIRE_LEN = 16,
    parameter int DEAD_LEN = 50
) (
    input  logic          clk_adc,
    input  logic          nrst,
    trig_arbiter_if.slave bus
);
    localparam logic [1:0]     S_IDLE    = 2'd0;
    localparam logic [1:0]     S_FIRE    = 2'd1;
    localparam logic [1:0]     S_DEAD    = 2'd2;
    localparam logic [31:0]    CNT_MAX   = 32'hFFFF_FFFF;
    localparam logic [7:0]     FIRE_LEN8 = 8'(FIRE_LEN);
    localparam logic [7:0]     DEAD_LEN8 = 8'(DEAD_LEN);
    localparam logic [NCH-1:0] ONE_HOT0  = {{(NCH-1){1'b0}}, 1'b1};

    logic [1:0]     state_q, state_d;
    logic [7:0]     tmr_q, tmr_d;
    logic [3:0]     last_grant_q, last_grant_d;
    logic [3:0]     grant_id_q, grant_id_d;
    logic [NCH-1:0] fire_out_q, fire_out_d;
    logic [NCH-1:0] req_prev_q;
    logic           busy_q;
    logic [31:0]    acc_cnt_q, acc_cnt_d;
    logic [31:0]    veto_cnt_q, veto_cnt_d;
    logic [31:0]    lost_cnt_q, lost_cnt_d;

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] req_rise;
    logic [3:0]     winner;
    logic           grant;
    logic           pass;
    logic           acc_inc, veto_inc, lost_inc;

    function automatic logic [31:0] cnt_next(input logic [31:0] cnt, input logic inc,
                                             input logic clr);
        if (clr) return '0;
        if (inc && (cnt != CNT_MAX)) return cnt + 32'd1;
        return cnt;
    endfunction

    assign eligible = bus.req & bus.chan_mask;
    assign req_rise = bus.req & ~req_prev_q & bus.chan_mask;
    assign grant    = (state_q == S_IDLE) && bus.enable && (|eligible);
    assign pass     = (bus.randnum <= bus.prescale);
    assign lost_inc = (state_q != S_IDLE) && (|req_rise);

    // Round-robin search: find the first eligible channel at or after last_grant+1, wrapping around
    always_comb begin
        logic       found;
        logic [4:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, last_grant_q} + 5'(i) + 5'd1;
            if (sum >= 5'(NCH)) sum = sum - 5'(NCH);
            if (!found && eligible[sum[3:0]]) begin
                found  = 1'b1;
                winner = sum[3:0];
            end
        end
    end

    // Control FSM: IDLE grants, FIRE holds the pulse, DEAD enforces the deadtime
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        fire_out_d   = fire_out_q;
        acc_inc      = 1'b0;
        veto_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    if (pass) begin
                        state_d    = S_FIRE;
                        tmr_d      = FIRE_LEN8;
                        fire_out_d = ONE_HOT0 << winner;
                        acc_inc    = 1'b1;
                    end else begin
                        state_d  = S_DEAD;
                        tmr_d    = DEAD_LEN8;
                        veto_inc = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                if (tmr_q <= 8'd1) begin
                    state_d    = S_DEAD;
                    tmr_d      = DEAD_LEN8;
                    fire_out_d = '0;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_DEAD: begin
                if (tmr_q <= 8'd1) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tmr_d      = '0;
                fire_out_d = '0;
            end
        endcase
    end

    // Saturating counters; a clear wins over an increment in the same cycle
    always_comb begin
        acc_cnt_d  = cnt_next(acc_cnt_q, acc_inc, bus.clear_counts);
        veto_cnt_d = cnt_next(veto_cnt_q, veto_inc, bus.clear_counts);
        lost_cnt_d = cnt_next(lost_cnt_q, lost_inc, bus.clear_counts);
    end

    // State and output registers; reset drops fire_out asynchronously
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            last_grant_q <= 4'(NCH - 1);
            grant_id_q   <= '0;
            fire_out_q   <= '0;
            req_prev_q   <= '0;
            busy_q       <= 1'b0;
            acc_cnt_q    <= '0;
            veto_cnt_q   <= '0;
            lost_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            fire_out_q   <= fire_out_d;
            req_prev_q   <= bus.req;
            busy_q       <= (state_d != S_IDLE);
            acc_cnt_q    <= acc_cnt_d;
            veto_cnt_q   <= veto_cnt_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    assign bus.fire_out     = fire_out_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.accepted_cnt = acc_cnt_q;
    assign bus.vetoed_cnt   = veto_cnt_q;
    assign bus.lost_cnt     = lost_cnt_q;
    assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_trig_arbiter.sv
// tb_trig_arbiter: table vectors, directed corner sequences and random stimulus
// for trig_arbiter, compared against a cycle-timeline reference model.
module tb_trig_arbiter;
    localparam int          NCH   = 16;
    localparam int          FL    = 16;
    localparam int          DL    = 50;
    localparam logic [31:0] MAX32 = 32'hFFFF_FFFF;

    logic clk_adc = 1'b0;
    logic nrst    = 1'b0;

    trig_arbiter_if #(.NCH(NCH)) bus();

    trig_arbiter #(.NCH(NCH), .FIRE_LEN(FL), .DEAD_LEN(DL)) dut (
        .clk_adc (clk_adc),
        .nrst    (nrst),
        .bus     (bus)
    );

    // Clock and watchdog
    always #5 clk_adc = ~clk_adc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. It keeps absolute edge numbers: the earliest edge at which
    // the next grant may occur, and the edge on which the current pulse began.
    int                m_cyc = 0;
    int                m_free_at;
    int                m_fire_from;
    logic [3:0]        m_last, m_gid, m_fire_ch;
    logic [NCH-1:0]    m_prev, m_fire;
    logic              m_busy;
    logic [31:0]       m_acc, m_veto, m_lost;
    logic [NCH-1:0]    one_h = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == MAX32) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_free_at   = 0;
        m_fire_from = -100000;
        m_last      = 4'(NCH - 1);
        m_gid       = 0;
        m_fire_ch   = 0;
        m_prev      = '0;
        m_fire      = '0;
        m_busy      = 1'b0;
        m_acc       = 0;
        m_veto      = 0;
        m_lost      = 0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] elig, rise;
        int n, w;
        bit found;
        m_cyc++;
        n = m_cyc;
        if (!nrst) begin
            model_reset();
            return;
        end
        elig   = bus.req & bus.chan_mask;
        rise   = elig & ~m_prev;
        m_prev = bus.req;
        if (n < m_free_at && rise != 0) m_lost = sat_inc(m_lost);
        if (n >= m_free_at && bus.enable && elig != 0) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (int'(m_last) + k) % NCH;
                if (!found && elig[c]) begin
                    found = 1;
                    w = c;
                end
            end
            m_last = 4'(w);
            m_gid  = 4'(w);
            if (bus.randnum <= bus.prescale) begin
                m_fire_ch   = 4'(w);
                m_fire_from = n;
                m_free_at   = n + FL + DL + 1;
                m_acc       = sat_inc(m_acc);
            end else begin
                m_free_at = n + DL + 1;
                m_veto    = sat_inc(m_veto);
            end
        end
        if (bus.clear_counts) begin
            m_acc  = 0;
            m_veto = 0;
            m_lost = 0;
        end
        m_busy = (n < m_free_at - 1);
        m_fire = (n >= m_fire_from && n < m_fire_from + FL) ? (one_h << m_fire_ch) : '0;
    endtask

    // Scoreboard: after each edge, compare every output with the model
    always @(posedge clk_adc) begin
        model_step();
        #2;
        chk("fire_out", 32'(bus.fire_out), 32'(m_fire));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("accepted_cnt", bus.accepted_cnt, m_acc);
        chk("vetoed_cnt", bus.vetoed_cnt, m_veto);
        chk("lost_cnt", bus.lost_cnt, m_lost);
        chk("fire_onehot", 32'($countones(bus.fire_out) <= 1), 32'd1);
    end

    // Driver tasks
    task automatic set_defaults();
        bus.req          = '0;
        bus.chan_mask    = '1;
        bus.enable       = 1'b0;
        bus.randnum      = 0;
        bus.prescale     = 0;
        bus.clear_counts = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_adc);
        nrst = 1'b0;
        model_reset();
        set_defaults();
        repeat (2) @(negedge clk_adc);
        nrst = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk_adc);
            k++;
        end
        chk("wait_idle", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] mask;
        logic [31:0]    randnum;
        logic [31:0]    prescale;
        logic [3:0]     exp_id;
        logic           exp_pass;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int             t_gr[8];
        logic [3:0]     id_gr[8];
        int             ngr, pw, cyc, blen;
        logic           prev_busy, fire_seen;
        logic [NCH-1:0] exp_fire;
        logic [31:0]    r32;

        tbl[0] = '{16'h0003, 16'hFFFF, 32'd0, MAX32, 4'd0,  1'b1};
        tbl[1] = '{16'h0003, 16'hFFFF, 32'd0, MAX32, 4'd1,  1'b1};
        tbl[2] = '{16'h0003, 16'hFFFF, 32'd0, MAX32, 4'd0,  1'b1};
        tbl[3] = '{16'h8001, 16'hFFFF, 32'd0, MAX32, 4'd15, 1'b1};
        tbl[4] = '{16'h8001, 16'hFFFF, 32'd0, MAX32, 4'd0,  1'b1};
        tbl[5] = '{16'h0F00, 16'h0C00, 32'd0, MAX32, 4'd10, 1'b1};
        tbl[6] = '{16'h0401, 16'hFFFF, 32'd5, 32'd0, 4'd0,  1'b0};
        tbl[7] = '{16'h0001, 16'hFFFF, 32'd7, 32'd7, 4'd0,  1'b1};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 32'd8, 32'd7, 4'd1,  1'b0};
        tbl[9] = '{16'h0050, 16'hFFFF, 32'd0, 32'd0, 4'd4,  1'b1};

        model_reset();
        set_defaults();
        do_reset();
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);

        // Table vectors: one grant per row, round-robin order from reset
        for (int i = 0; i < 10; i++) begin
            bus.req       = tbl[i].req;
            bus.chan_mask = tbl[i].mask;
            bus.randnum   = tbl[i].randnum;
            bus.prescale  = tbl[i].prescale;
            bus.enable    = 1'b1;
            @(negedge clk_adc);
            exp_fire = tbl[i].exp_pass ? (one_h << tbl[i].exp_id) : '0;
            chk("tbl_busy", 32'(bus.busy), 32'd1);
            chk("tbl_grant_id", 32'(bus.grant_id), 32'(tbl[i].exp_id));
            chk("tbl_fire_out", 32'(bus.fire_out), 32'(exp_fire));
            bus.req = '0;
            wait_idle(200);
            @(negedge clk_adc);
        end

        // Held req 0x0003: alternating grants, pulse width and grant spacing
        do_reset();
        bus.req      = 16'h0003;
        bus.prescale = MAX32;
        bus.enable   = 1'b1;
        ngr = 0; pw = 0; cyc = 0; prev_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            t_gr[k]  = -1000;
            id_gr[k] = 4'hF;
        end
        repeat (210) begin
            @(negedge clk_adc);
            cyc++;
            if (bus.busy && !prev_busy && ngr < 8) begin
                t_gr[ngr]  = cyc;
                id_gr[ngr] = bus.grant_id;
                ngr++;
            end
            if (ngr == 1 && bus.fire_out != 0) pw++;
            prev_busy = bus.busy;
        end
        chk("alt_ngrants_ge3", 32'(ngr >= 3), 32'd1);
        chk("alt_id0", 32'(id_gr[0]), 32'd0);
        chk("alt_id1", 32'(id_gr[1]), 32'd1);
        chk("alt_id2", 32'(id_gr[2]), 32'd0);
        chk("alt_pulse_width", 32'(pw), 32'(FL));
        chk("alt_spacing01", 32'(t_gr[1] - t_gr[0]), 32'(FL + DL + 1));
        chk("alt_spacing12", 32'(t_gr[2] - t_gr[1]), 32'(FL + DL + 1));
        bus.req = '0;
        wait_idle(200);

        // Veto: no pulse, busy for exactly the deadtime
        do_reset();
        bus.prescale = 0;
        bus.randnum  = 5;
        bus.enable   = 1'b1;
        bus.req      = 16'h0008;
        @(negedge clk_adc);
        bus.req = '0;
        blen = 0; fire_seen = 1'b0;
        while (bus.busy && blen < 200) begin
            blen++;
            if (bus.fire_out != 0) fire_seen = 1'b1;
            @(negedge clk_adc);
        end
        chk("veto_busy_len", 32'(blen), 32'(DL));
        chk("veto_no_fire", 32'(fire_seen), 32'd0);
        chk("veto_count", bus.vetoed_cnt, 32'd1);

        // Lost edges: two simultaneous rises count once, a later rise counts again
        do_reset();
        bus.prescale = MAX32;
        bus.enable   = 1'b1;
        bus.req      = 16'h0001;
        @(negedge clk_adc);
        bus.req = 16'h0211;
        repeat (10) @(negedge clk_adc);
        bus.req = 16'h0291;
        wait_idle(200);
        chk("lost_two", bus.lost_cnt, 32'd2);
        bus.req = '0;
        @(negedge clk_adc);

        // Mask blocks the only requester, then unmasking grants it
        do_reset();
        bus.prescale  = MAX32;
        bus.enable    = 1'b1;
        bus.chan_mask = 16'hFFFE;
        bus.req       = 16'h0001;
        repeat (5) @(negedge clk_adc);
        chk("mask_no_grant", 32'(bus.busy), 32'd0);
        bus.chan_mask = 16'hFFFF;
        @(negedge clk_adc);
        chk("mask_grant_id", 32'(bus.grant_id), 32'd0);
        chk("mask_accepted", bus.accepted_cnt, 32'd1);
        bus.req = '0;
        wait_idle(200);

        // Asynchronous reset in the middle of a pulse
        bus.req = 16'h0001;
        @(negedge clk_adc);
        repeat (4) @(negedge clk_adc);
        chk("pre_reset_fire", 32'(bus.fire_out), 32'h1);
        nrst = 1'b0;
        model_reset();
        #1;
        chk("async_fire_out", 32'(bus.fire_out), 32'd0);
        chk("async_accepted", bus.accepted_cnt, 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        bus.req = 16'h0004;
        @(negedge clk_adc);
        @(negedge clk_adc);
        nrst = 1'b1;
        @(negedge clk_adc);
        chk("post_reset_grant_id", 32'(bus.grant_id), 32'd2);
        chk("post_reset_fire", 32'(bus.fire_out), 32'h4);
        bus.req = '0;
        wait_idle(200);

        // Saturation and clear-over-increment
        force dut.acc_cnt_q  = MAX32;
        force dut.veto_cnt_q = MAX32;
        m_acc  = MAX32;
        m_veto = MAX32;
        @(posedge clk_adc);
        #1;
        release dut.acc_cnt_q;
        release dut.veto_cnt_q;
        @(negedge clk_adc);
        bus.prescale = MAX32;
        bus.req      = 16'h0001;
        @(negedge clk_adc);
        chk("sat_accepted", bus.accepted_cnt, MAX32);
        bus.req = '0;
        wait_idle(200);
        bus.prescale = 0;
        bus.randnum  = 1;
        bus.req      = 16'h0002;
        @(negedge clk_adc);
        chk("sat_vetoed", bus.vetoed_cnt, MAX32);
        bus.req = '0;
        wait_idle(200);
        bus.prescale     = MAX32;
        bus.req          = 16'h0001;
        bus.clear_counts = 1'b1;
        @(negedge clk_adc);
        chk("clear_accepted", bus.accepted_cnt, 32'd0);
        chk("clear_vetoed", bus.vetoed_cnt, 32'd0);
        chk("clear_keeps_fsm", 32'(bus.busy), 32'd1);
        bus.clear_counts = 1'b0;
        bus.req          = '0;
        wait_idle(200);

        // Random stimulus against the model
        for (int it = 0; it < 300; it++) begin
            r32 = 32'd1 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) r32 = r32 | $urandom;
            if ($urandom_range(0, 3) == 0) r32 = 0;
            bus.req       = r32[NCH-1:0];
            r32           = $urandom;
            bus.chan_mask = ($urandom_range(0, 3) == 0) ? r32[NCH-1:0] : '1;
            bus.enable    = ($urandom_range(0, 9) != 0);
            bus.randnum   = $urandom_range(0, 15);
            bus.prescale  = $urandom_range(0, 15);
            repeat ($urandom_range(1, 30)) begin
                bus.clear_counts = ($urandom_range(0, 63) == 0);
                @(negedge clk_adc);
            end
            bus.clear_counts = 1'b0;
        end
        bus.req = '0;
        wait_idle(200);
        @(negedge clk_adc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
